// File: rtl/wm_embed_sequencer.sv
// Watermark embed sequencer: walks the image in raster order, reading each pixel and
// its watermark bit, replacing the pixel LSB with that bit, and writing the pixel back.
module wm_embed_sequencer #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int ROW_W = 3,
    parameter int COL_W = 3,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [ROW_W-1:0] row_signal,
    output logic [COL_W-1:0] col_signal,
    output logic             IM_RD_WRn,
    output logic             WM_RD_WRn,
    input  logic [PIX_W-1:0] IM_data_in,
    input  logic             WM_data_in,
    output logic [PIX_W-1:0] Reg_IM_data_out,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EMBED,
        S_WRITE
    } state_t;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [PIX_W-1:0] data_q, data_d;
    logic             done_q, done_d;
    logic             im_rd_wrn_q, im_rd_wrn_d;

    // The pixel LSB is always overwritten by the watermark bit.
    logic unused_pix_lsb;
    assign unused_pix_lsb = IM_data_in[0];

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_READ: state_d = S_EMBED;
            S_EMBED: begin
                data_d  = {IM_data_in[PIX_W-1:1], WM_data_in};
                state_d = S_WRITE;
            end
            S_WRITE: begin
                // Wrap is explicit at the last index so odd sizes never address past the end.
                if (col_q != COL_LAST) begin
                    col_d   = col_q + COL_W'(1);
                    state_d = S_READ;
                end else if (row_q != ROW_LAST) begin
                    col_d   = '0;
                    row_d   = row_q + ROW_W'(1);
                    state_d = S_READ;
                end else begin
                    col_d   = '0;
                    row_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Strobes are decoded from the next state so they leave the flops glitch-free.
        done_d      = (state_d == S_IDLE);
        im_rd_wrn_d = (state_d != S_WRITE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            data_q      <= '0;
            done_q      <= 1'b1;
            im_rd_wrn_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            data_q      <= data_d;
            done_q      <= done_d;
            im_rd_wrn_q <= im_rd_wrn_d;
        end
    end

    assign row_signal      = row_q;
    assign col_signal      = col_q;
    assign IM_RD_WRn       = im_rd_wrn_q;
    assign WM_RD_WRn       = 1'b1;
    assign Reg_IM_data_out = data_q;
    assign done            = done_q;

endmodule

// File: tb/tb_wm_embed_sequencer.sv
// Bench for wm_embed_sequencer: a 2x2 and a 3x3 instance, each with a 1-cycle-latency
// image/watermark memory model, table-driven pass checks plus start/reset corner cases.
module tb_wm_embed_sequencer;

    typedef struct {
        logic [7:0] pix;
        logic       wm;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start2, start3, clr, load;
    int   checks = 0;
    int   errors = 0;

    // 2x2 instance
    logic [0:0] row2, col2;
    logic       im2, wmrw2, done2, wmbit2;
    logic [7:0] rd2, dout2;
    logic [7:0] mem2[4];
    logic       wmm2[4];
    logic [7:0] init_pix2[4];
    logic       init_wm2[4];
    logic [1:0] wlog2[8];
    int         wr_cnt2, low_cnt2;
    logic       bad2;

    // 3x3 instance on 2-bit addresses, memory indexed by {row,col}
    logic [1:0] row3, col3;
    logic       im3, wmrw3, done3, wmbit3;
    logic [7:0] rd3, dout3;
    logic [7:0] mem3[16];
    logic       wmm3[16];
    logic [7:0] init_pix3[16];
    logic       init_wm3[16];
    logic [3:0] wlog3[16];
    int         wr_cnt3, low_cnt3;
    logic       bad3, oob3;

    wm_embed_sequencer #(.ROWS(2), .COLS(2), .ROW_W(1), .COL_W(1), .PIX_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .row_signal(row2), .col_signal(col2),
        .IM_RD_WRn(im2), .WM_RD_WRn(wmrw2),
        .IM_data_in(rd2), .WM_data_in(wmbit2),
        .Reg_IM_data_out(dout2), .done(done2)
    );

    wm_embed_sequencer #(.ROWS(3), .COLS(3), .ROW_W(2), .COL_W(2), .PIX_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .row_signal(row3), .col_signal(col3),
        .IM_RD_WRn(im3), .WM_RD_WRn(wmrw3),
        .IM_data_in(rd3), .WM_data_in(wmbit3),
        .Reg_IM_data_out(dout3), .done(done3)
    );

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 4; i++) begin
                mem2[i] <= init_pix2[i];
                wmm2[i] <= init_wm2[i];
            end
            for (int i = 0; i < 16; i++) begin
                mem3[i] <= init_pix3[i];
                wmm3[i] <= init_wm3[i];
            end
        end else begin
            if (!im2) mem2[{row2, col2}] <= dout2;
            if (!im3) mem3[{row3, col3}] <= dout3;
        end
        rd2    <= mem2[{row2, col2}];
        wmbit2 <= wmm2[{row2, col2}];
        rd3    <= mem3[{row3, col3}];
        wmbit3 <= wmm3[{row3, col3}];
        if (clr) begin
            wr_cnt2  <= 0;
            low_cnt2 <= 0;
            bad2     <= 1'b0;
            wr_cnt3  <= 0;
            low_cnt3 <= 0;
            bad3     <= 1'b0;
            oob3     <= 1'b0;
        end else begin
            if (!im2) begin
                if (wr_cnt2 < 8) wlog2[wr_cnt2[2:0]] <= {row2, col2};
                wr_cnt2 <= wr_cnt2 + 1;
            end
            if (!im3) begin
                if (wr_cnt3 < 16) wlog3[wr_cnt3[3:0]] <= {row3, col3};
                wr_cnt3 <= wr_cnt3 + 1;
            end
            if (!done2) low_cnt2 <= low_cnt2 + 1;
            if (!done3) low_cnt3 <= low_cnt3 + 1;
            if ((!im2 && done2) || !wmrw2) bad2 <= 1'b1;
            if ((!im3 && done3) || !wmrw3) bad3 <= 1'b1;
            if (col3 == 2'd3 || row3 == 2'd3) oob3 <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_mem();
        load = 1'b1;
        clr  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        clr  = 1'b0;
    endtask

    task automatic wait_idle2();
        int n = 0;
        while (done2 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle2_in_time", 32'(n < 200), 32'd1);
    endtask

    task automatic wait_idle3();
        int n = 0;
        while (done3 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle3_in_time", 32'(n < 200), 32'd1);
    endtask

    function automatic logic [3:0] idx3(input int i);
        return 4'(((i / 3) * 4) + (i % 3));
    endfunction

    vec_t v2[4];
    vec_t v3[9];
    logic samp[40];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        start2 = 1'b0;
        start3 = 1'b0;
        clr    = 1'b1;
        load   = 1'b0;

        v2[0] = '{8'h10, 1'b1, 8'h11};
        v2[1] = '{8'h11, 1'b0, 8'h10};
        v2[2] = '{8'hFE, 1'b1, 8'hFF};
        v2[3] = '{8'hFF, 1'b0, 8'hFE};

        v3[0] = '{8'h00, 1'b1, 8'h01};
        v3[1] = '{8'h01, 1'b1, 8'h01};
        v3[2] = '{8'h7F, 1'b0, 8'h7E};
        v3[3] = '{8'h80, 1'b1, 8'h81};
        v3[4] = '{8'hAA, 1'b1, 8'hAB};
        v3[5] = '{8'h55, 1'b0, 8'h54};
        v3[6] = '{8'hFF, 1'b0, 8'hFE};
        v3[7] = '{8'hFE, 1'b1, 8'hFF};
        v3[8] = '{8'h3C, 1'b0, 8'h3C};

        for (int i = 0; i < 4; i++) begin
            init_pix2[i] = v2[i].pix;
            init_wm2[i]  = v2[i].wm;
        end
        for (int i = 0; i < 16; i++) begin
            init_pix3[i] = 8'h00;
            init_wm3[i]  = 1'b0;
        end
        for (int i = 0; i < 9; i++) begin
            init_pix3[idx3(i)] = v3[i].pix;
            init_wm3[idx3(i)]  = v3[i].wm;
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_done2", 32'(done2), 32'd1);
        check("rst_im2", 32'(im2), 32'd1);
        check("rst_wm2", 32'(wmrw2), 32'd1);
        check("rst_row2", 32'(row2), 32'd0);
        check("rst_col2", 32'(col2), 32'd0);
        check("rst_data2", 32'(dout2), 32'd0);
        check("rst_done3", 32'(done3), 32'd1);
        check("rst_row3", 32'(row3), 32'd0);
        check("rst_col3", 32'(col3), 32'd0);
        check("rst_data3", 32'(dout3), 32'd0);
        rst_n = 1'b1;

        // Basic 2x2 pass
        load_mem();
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("basic_c1_done", 32'(done2), 32'd0);
        check("basic_c1_rd", 32'(im2), 32'd1);
        wait_idle2();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("basic_pix%0d", i), 32'(mem2[i]), 32'(v2[i].exp));
            check($sformatf("basic_addr%0d", i), 32'(wlog2[i]), 32'(i));
        end
        check("basic_low_cycles", 32'(low_cnt2), 32'd12);
        check("basic_writes", 32'(wr_cnt2), 32'd4);
        check("basic_strobes", 32'(bad2), 32'd0);

        // start re-pulsed at pass cycles 1 and 5 is ignored
        load_mem();
        start2 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start2 = 1'b0;
        repeat (3) @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        wait_idle2();
        repeat (2) @(negedge clk);
        check("ignore_still_idle", 32'(done2), 32'd1);
        check("ignore_low_cycles", 32'(low_cnt2), 32'd12);
        check("ignore_writes", 32'(wr_cnt2), 32'd4);

        // start held high for 40 cycles: 12 busy, 1 idle, repeating
        load_mem();
        start2 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            samp[c] = done2;
        end
        start2 = 1'b0;
        begin
            int   len = 1;
            int   lo_runs = 0;
            logic prev = samp[0];
            check("held_first_busy", 32'(samp[0]), 32'd0);
            for (int c = 1; c < 40; c++) begin
                if (samp[c] == prev) begin
                    len++;
                end else begin
                    if (prev == 1'b0) begin
                        check("held_low_run", 32'(len), 32'd12);
                        lo_runs++;
                    end else begin
                        check("held_high_run", 32'(len), 32'd1);
                    end
                    prev = samp[c];
                    len  = 1;
                end
            end
            check("held_pass_count", 32'(lo_runs), 32'd3);
        end
        wait_idle2();

        // Reset asserted in pixel (0,1) so its write never happens
        load_mem();
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_addr_col", 32'(col2), 32'd1);
        check("midrst_pre_strobe", 32'(im2), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_done", 32'(done2), 32'd1);
        check("midrst_strobe", 32'(im2), 32'd1);
        check("midrst_row", 32'(row2), 32'd0);
        check("midrst_col", 32'(col2), 32'd0);
        check("midrst_data", 32'(dout2), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_pix0", 32'(mem2[0]), 32'h11);
        check("midrst_pix1", 32'(mem2[1]), 32'h11);
        check("midrst_pix2", 32'(mem2[2]), 32'hFE);
        check("midrst_pix3", 32'(mem2[3]), 32'hFF);
        check("midrst_writes", 32'(wr_cnt2), 32'd1);

        // Fresh start after reset begins at (0,0)
        clr = 1'b1;
        @(negedge clk);
        clr    = 1'b0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("restart_done", 32'(done2), 32'd0);
        check("restart_row", 32'(row2), 32'd0);
        check("restart_col", 32'(col2), 32'd0);
        wait_idle2();
        check("restart_writes", 32'(wr_cnt2), 32'd4);
        check("restart_first_addr", 32'(wlog2[0]), 32'd0);
        for (int i = 0; i < 4; i++)
            check($sformatf("restart_pix%0d", i), 32'(mem2[i]), 32'(v2[i].exp));

        // 3x3 pass on 2-bit addresses
        load_mem();
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        wait_idle3();
        for (int i = 0; i < 9; i++) begin
            check($sformatf("np2_pix%0d", i), 32'(mem3[idx3(i)]), 32'(v3[i].exp));
            check($sformatf("np2_addr%0d", i), 32'(wlog3[i]), 32'(idx3(i)));
        end
        check("np2_low_cycles", 32'(low_cnt3), 32'd27);
        check("np2_writes", 32'(wr_cnt3), 32'd9);
        check("np2_in_range", 32'(oob3), 32'd0);
        check("np2_strobes", 32'(bad3), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
